axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
- Single-outstanding AXI4 master DUV, the initiator counterpart to the SRAM_wrapper slave.
- Converts a simple command/data stream interface into INCR bursts on the M_* AXI channels.
- Used by the master-side VIP bench, paired with the axi4 slave VIP/monitor, and by the future CPU/DMA front ends.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; only 32 is supported (AxSize fixed at 3'b010).
- ID_WIDTH, 4, AXI ID width.
- LEN_WIDTH, 4, AxLen width; burst of 1..16 beats.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_WIDTH  start byte address; bits[1:0] are forced to 0.
- cmd_len  in  LEN_WIDTH  beats-1.
- cmd_id  in  ID_WIDTH  transaction ID.
- wr_data/wr_strb  in  DATA_WIDTH/DATA_WIDTH/8  write beat payload.
- wr_valid/wr_ready  in/out  1/1  write beat handshake.
- rd_data  out  DATA_WIDTH  read beat payload.
- rd_last  out  1  final read beat.
- rd_valid/rd_ready  out/in  1/1  read beat handshake.
- rsp_valid/rsp_ready  out/in  1/1  completion handshake.
- rsp_resp  out  2  final response.
- rsp_write  out  1  completion kind.
- protocol_err  out  1  one-cycle pulse on slave protocol violation.
- AW channel: M_AWID, M_AWAddr, M_AWLen, M_AWSize, M_AWBurst, M_AWValid out; M_AWReady in.
- W channel: M_WData, M_WStrb, M_WLast, M_WValid out; M_WReady in.
- B channel: M_BID, M_BResp, M_BValid in; M_BReady out.
- AR channel: M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid out; M_ARReady in.
- R channel: M_RID, M_RData, M_RResp, M_RLast, M_RValid in; M_RReady out.

Behaviour:
- Reset: state=IDLE.
  - All valids, M_BReady, M_RReady, rsp_valid and protocol_err are 0.
  - Address, ID, len and counter registers are 0.
  - AxSize=3'b010 and AxBurst=2'b01 (INCR) are constants.
- States: IDLE, AW, W, B, AR, R, RSP.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - On cmd_valid&cmd_ready, latch addr, len, id and write.
  - Next state is AW if write, else AR.
  - beat_cnt=0, resp_acc=OKAY.
- AW/AR:
  - M_AxValid is registered high on entry and held stable, with its payload, until M_AxReady.
  - Then go to W (write) or R (read).
  - AxValid never depends combinationally on AxReady.
- W:
  - M_WValid=wr_valid, wr_ready=M_WReady, M_WData/M_WStrb=wr_data/wr_strb (combinational pass-through).
  - M_WLast=(beat_cnt==len).
  - beat_cnt increments on each W handshake.
  - After the handshake with WLast=1, go to B.
- B:
  - M_BReady=1.
  - On M_BValid: capture BResp into rsp_resp and go to RSP.
  - If BID!=latched id, pulse protocol_err.
- R:
  - rd_valid=M_RValid, M_RReady=rd_ready, rd_data=M_RData.
  - rd_last=(beat_cnt==len), not M_RLast.
  - On each handshake: resp_acc=max(resp_acc, RResp), beat_cnt++.
  - Pulse protocol_err if M_RLast!=(beat_cnt==len) or RID!=id.
  - After the handshake on the beat_cnt==len beat, go to RSP with rsp_resp=max(acc, last RResp).
- RSP:
  - rsp_valid=1 and rsp_write=latched write, held until rsp_ready, then return to IDLE.
  - No new command is accepted until then.
- Boundaries:
  - len=0 means one beat; WLast/rd_last assert on the first beat.
  - The beat counter is LEN_WIDTH+1 wide, so len=15 does not wrap early.
  - 4KB crossing is not checked; the caller is responsible.
  - A simultaneous B/R valid and ready in the state's first cycle is accepted that cycle.
  - Reset mid-burst: immediate return to IDLE with all valids low; the slave is also reset by the bench.
- Latency:
  - cmd handshake to AxValid: 1 cycle.
  - Last B/R handshake to rsp_valid: 1 cycle.

Decomposition:
- Package axi_master_pkg holds:
  - state_t enum;
  - constants AXI_SIZE_WORD=3'b010 and AXI_BURST_INCR=2'b01;
  - resp codes OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
- No sub-module: the FSM, beat counter and response accumulator live in one always_ff/always_comb pair.

Test Plan:
- Write addr=0x100, len=3, id=2, data 0xA0..0xA3, slave AWReady delayed 2 cycles:
  - AW payload is held stable until AWReady;
  - WLast is set on the 4th beat only;
  - BResp=OKAY gives rsp_valid with rsp_resp=0 and rsp_write=1.
- Read addr=0x100, len=3: rd_data=0xA0..0xA3, rd_last on beat 4, rsp_resp=0.
- Read len=0 with rd_ready toggling 1/0: a single beat, no beat is lost, M_RReady mirrors rd_ready.
- Read len=15 with beat 7 RResp=SLVERR: all 16 beats are delivered and rsp_resp=2.
- Slave asserts RLast on beat 2 of a len=3 read, or returns BID=5 for id=2: protocol_err pulses exactly once.
- ARESETn low during the W phase at beat 1: all valids are 0 immediately, and a fresh command after reset completes normally.

Source files
------------

// File: rtl/axi_master_pkg.sv
// Shared types and constants for the single-outstanding AXI4 burst master.
package axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_RSP  = 3'd6
    } state_t;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] EXOKAY = 2'd1;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    // Worst-of-two response; the encoding is ordered by severity.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 master: turns a command/data stream into INCR bursts
// and reports one completion per command.
module axi_burst_master
    import axi_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [ID_WIDTH-1:0]     cmd_id,

    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    wr_valid,
    output logic                    wr_ready,

    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    rd_valid,
    input  logic                    rd_ready,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_write,
    output logic                    protocol_err,
    output state_t                  dbg_state,

    output logic [ID_WIDTH-1:0]     M_AWID,
    output logic [ADDR_WIDTH-1:0]   M_AWAddr,
    output logic [LEN_WIDTH-1:0]    M_AWLen,
    output logic [2:0]              M_AWSize,
    output logic [1:0]              M_AWBurst,
    output logic                    M_AWValid,
    input  logic                    M_AWReady,

    output logic [DATA_WIDTH-1:0]   M_WData,
    output logic [DATA_WIDTH/8-1:0] M_WStrb,
    output logic                    M_WLast,
    output logic                    M_WValid,
    input  logic                    M_WReady,

    input  logic [ID_WIDTH-1:0]     M_BID,
    input  logic [1:0]              M_BResp,
    input  logic                    M_BValid,
    output logic                    M_BReady,

    output logic [ID_WIDTH-1:0]     M_ARID,
    output logic [ADDR_WIDTH-1:0]   M_ARAddr,
    output logic [LEN_WIDTH-1:0]    M_ARLen,
    output logic [2:0]              M_ARSize,
    output logic [1:0]              M_ARBurst,
    output logic                    M_ARValid,
    input  logic                    M_ARReady,

    input  logic [ID_WIDTH-1:0]     M_RID,
    input  logic [DATA_WIDTH-1:0]   M_RData,
    input  logic [1:0]              M_RResp,
    input  logic                    M_RLast,
    input  logic                    M_RValid,
    output logic                    M_RReady
);

    // Handshake rule on every channel: a beat transfers on a rising ACLK edge
    // where valid and ready are both high; a raised valid keeps its payload
    // stable until that edge.

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  write_q, write_d;
    logic [LEN_WIDTH:0]    cnt_q, cnt_d;
    logic [1:0]            acc_q, acc_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  perr_q, perr_d;
    logic                  last_beat;

    // One extra counter bit keeps len=15 from wrapping before the final beat.
    assign last_beat = (cnt_q == {1'b0, len_q});

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            id_q       <= '0;
            write_q    <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= OKAY;
            rsp_resp_q <= OKAY;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            id_q       <= id_d;
            write_q    <= write_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rsp_resp_q <= rsp_resp_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        id_d       = id_q;
        write_d    = write_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        rsp_resp_d = rsp_resp_q;
        perr_d     = 1'b0;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        M_WValid   = 1'b0;
        M_BReady   = 1'b0;
        M_RReady   = 1'b0;
        rd_valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ~ADDR_WIDTH'(3);
                    len_d   = cmd_len;
                    id_d    = cmd_id;
                    write_d = cmd_write;
                    cnt_d   = '0;
                    acc_d   = OKAY;
                    state_d = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                if (M_AWReady) state_d = ST_W;
            end
            ST_W: begin
                M_WValid = wr_valid;
                wr_ready = M_WReady;
                if (wr_valid && M_WReady) begin
                    cnt_d = cnt_q + {{LEN_WIDTH{1'b0}}, 1'b1};
                    if (last_beat) state_d = ST_B;
                end
            end
            ST_B: begin
                M_BReady = 1'b1;
                if (M_BValid) begin
                    rsp_resp_d = M_BResp;
                    perr_d     = (M_BID != id_q);
                    state_d    = ST_RSP;
                end
            end
            ST_AR: begin
                if (M_ARReady) state_d = ST_R;
            end
            ST_R: begin
                rd_valid = M_RValid;
                M_RReady = rd_ready;
                if (M_RValid && rd_ready) begin
                    acc_d  = resp_max(acc_q, M_RResp);
                    cnt_d  = cnt_q + {{LEN_WIDTH{1'b0}}, 1'b1};
                    perr_d = (M_RLast != last_beat) || (M_RID != id_q);
                    if (last_beat) begin
                        rsp_resp_d = resp_max(acc_q, M_RResp);
                        state_d    = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address valids come straight from the state register, never from ready.
    assign M_AWValid = (state_q == ST_AW);
    assign M_ARValid = (state_q == ST_AR);
    assign M_AWID    = id_q;
    assign M_AWAddr  = addr_q;
    assign M_AWLen   = len_q;
    assign M_AWSize  = AXI_SIZE_WORD;
    assign M_AWBurst = AXI_BURST_INCR;
    assign M_ARID    = id_q;
    assign M_ARAddr  = addr_q;
    assign M_ARLen   = len_q;
    assign M_ARSize  = AXI_SIZE_WORD;
    assign M_ARBurst = AXI_BURST_INCR;

    assign M_WData   = wr_data;
    assign M_WStrb   = wr_strb;
    assign M_WLast   = (state_q == ST_W) && last_beat;
    assign rd_data   = M_RData;
    assign rd_last   = (state_q == ST_R) && last_beat;

    assign rsp_valid    = (state_q == ST_RSP);
    assign rsp_write    = write_q;
    assign rsp_resp     = rsp_resp_q;
    assign protocol_err = perr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: the bench plays the AXI slave by hand.
module tb_axi_burst_master;
    import axi_master_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len, cmd_id;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        rsp_valid, rsp_ready, rsp_write, protocol_err;
    logic [1:0]  rsp_resp;
    state_t      dbg_state;
    logic [3:0]  M_AWID, M_AWLen, M_ARID, M_ARLen, M_BID, M_RID;
    logic [31:0] M_AWAddr, M_ARAddr, M_WData, M_RData;
    logic [2:0]  M_AWSize, M_ARSize;
    logic [1:0]  M_AWBurst, M_ARBurst, M_BResp, M_RResp;
    logic        M_AWValid, M_AWReady, M_WLast, M_WValid, M_WReady;
    logic [3:0]  M_WStrb;
    logic        M_BValid, M_BReady, M_ARValid, M_ARReady;
    logic        M_RLast, M_RValid, M_RReady;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] wcap [0:3];

    axi_burst_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
        .rsp_write(rsp_write), .protocol_err(protocol_err), .dbg_state(dbg_state),
        .M_AWID(M_AWID), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen), .M_AWSize(M_AWSize),
        .M_AWBurst(M_AWBurst), .M_AWValid(M_AWValid), .M_AWReady(M_AWReady),
        .M_WData(M_WData), .M_WStrb(M_WStrb), .M_WLast(M_WLast), .M_WValid(M_WValid),
        .M_WReady(M_WReady),
        .M_BID(M_BID), .M_BResp(M_BResp), .M_BValid(M_BValid), .M_BReady(M_BReady),
        .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen), .M_ARSize(M_ARSize),
        .M_ARBurst(M_ARBurst), .M_ARValid(M_ARValid), .M_ARReady(M_ARReady),
        .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast),
        .M_RValid(M_RValid), .M_RReady(M_RReady)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic issue_cmd(input logic wr, input logic [31:0] addr,
                             input logic [3:0] len, input logic [3:0] id);
        int budget = 20;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
        while (!cmd_ready && budget > 0) begin tick(); budget--; end
        if (budget == 0) begin
            n_cmp++; n_err++;
            $display("FAIL cmd_ready_timeout: got 0 want 1");
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic ar_accept();
        M_ARReady = 1'b1; tick(); M_ARReady = 1'b0;
    endtask

    task automatic rsp_accept();
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) tick();
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if ({M_AWValid, M_ARValid, M_WValid, M_BReady, M_RReady, rsp_valid, protocol_err} !== 7'b0) begin
            n_err++; $display("FAIL rst_valids: got %b want 0000000",
                {M_AWValid, M_ARValid, M_WValid, M_BReady, M_RReady, rsp_valid, protocol_err});
        end
        n_cmp++; if ({M_AWAddr, M_AWID, M_AWLen} !== 40'h0) begin n_err++; $display("FAIL rst_regs: got %h want 0", {M_AWAddr, M_AWID, M_AWLen}); end
        n_cmp++; if ({M_AWSize, M_AWBurst, M_ARSize, M_ARBurst} !== 10'b010_01_010_01) begin
            n_err++; $display("FAIL rst_size_burst: got %b want 0100101001", {M_AWSize, M_AWBurst, M_ARSize, M_ARBurst});
        end
        @(negedge ACLK) ARESETn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        issue_cmd(1'b1, 32'h0000_0103, 4'd3, 4'd2);
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if ({M_AWValid, M_AWAddr, M_AWLen, M_AWID} !== {1'b1, 32'h100, 4'd3, 4'd2}) begin
                n_err++; $display("FAIL aw_hold cycle %0d: got v=%b a=%h l=%0d id=%0d want v=1 a=100 l=3 id=2",
                    c, M_AWValid, M_AWAddr, M_AWLen, M_AWID);
            end
            if (c == 2) M_AWReady = 1'b1;
            tick();
        end
        M_AWReady = 1'b0;
        n_cmp++; if (M_AWValid !== 1'b0) begin n_err++; $display("FAIL aw_drop: got %b want 0", M_AWValid); end
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = 32'hA0 + i; wr_strb = 4'hF; M_WReady = 1'b1;
            #1;
            n_cmp++; if ({M_WValid, wr_ready, M_WData, M_WLast} !== {1'b1, 1'b1, 32'hA0 + i, (i == 3)}) begin
                n_err++; $display("FAIL w_beat %0d: got v=%b r=%b d=%h last=%b want v=1 r=1 d=%h last=%b",
                    i, M_WValid, wr_ready, M_WData, M_WLast, 32'hA0 + i, (i == 3));
            end
            wcap[i] = M_WData;
            tick();
        end
        wr_valid = 1'b0; M_WReady = 1'b0;
        n_cmp++; if (M_BReady !== 1'b1) begin n_err++; $display("FAIL b_ready: got %b want 1", M_BReady); end
        M_BValid = 1'b1; M_BID = 4'd2; M_BResp = OKAY;
        tick();
        M_BValid = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_resp, rsp_write, protocol_err} !== 5'b1_00_1_0) begin
            n_err++; $display("FAIL w_rsp: got v=%b resp=%0d wr=%b perr=%b want v=1 resp=0 wr=1 perr=0",
                rsp_valid, rsp_resp, rsp_write, protocol_err);
        end
        rsp_accept();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL w_back_idle: got %b want 1", cmd_ready); end
    endtask

    task automatic test_read();
        issue_cmd(1'b0, 32'h100, 4'd3, 4'd2);
        n_cmp++; if ({M_ARValid, M_ARAddr, M_ARLen, M_ARID} !== {1'b1, 32'h100, 4'd3, 4'd2}) begin
            n_err++; $display("FAIL ar_payload: got v=%b a=%h l=%0d id=%0d want v=1 a=100 l=3 id=2",
                M_ARValid, M_ARAddr, M_ARLen, M_ARID);
        end
        ar_accept();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            M_RValid = 1'b1; M_RData = wcap[i]; M_RID = 4'd2; M_RResp = OKAY; M_RLast = (i == 3);
            #1;
            n_cmp++; if ({rd_valid, M_RReady, rd_data, rd_last} !== {1'b1, 1'b1, 32'hA0 + i, (i == 3)}) begin
                n_err++; $display("FAIL r_beat %0d: got v=%b r=%b d=%h last=%b want v=1 r=1 d=%h last=%b",
                    i, rd_valid, M_RReady, rd_data, rd_last, 32'hA0 + i, (i == 3));
            end
            tick();
        end
        M_RValid = 1'b0; rd_ready = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_resp, rsp_write, protocol_err} !== 5'b1_00_0_0) begin
            n_err++; $display("FAIL r_rsp: got v=%b resp=%0d wr=%b perr=%b want v=1 resp=0 wr=0 perr=0",
                rsp_valid, rsp_resp, rsp_write, protocol_err);
        end
        rsp_accept();
    endtask

    task automatic test_read_len0_toggle();
        issue_cmd(1'b0, 32'h200, 4'd0, 4'd3);
        ar_accept();
        M_RValid = 1'b1; M_RData = 32'h55; M_RID = 4'd3; M_RResp = OKAY; M_RLast = 1'b1;
        rd_ready = 1'b0;
        #1;
        n_cmp++; if ({M_RReady, rd_valid, rd_last} !== 3'b011) begin
            n_err++; $display("FAIL l0_stall: got rr=%b v=%b last=%b want rr=0 v=1 last=1", M_RReady, rd_valid, rd_last);
        end
        tick();
        n_cmp++; if (dbg_state !== ST_R) begin n_err++; $display("FAIL l0_held: got %0d want 5", dbg_state); end
        rd_ready = 1'b1;
        #1;
        n_cmp++; if ({M_RReady, rd_data} !== {1'b1, 32'h55}) begin
            n_err++; $display("FAIL l0_accept: got rr=%b d=%h want rr=1 d=55", M_RReady, rd_data);
        end
        tick();
        M_RValid = 1'b0; rd_ready = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_resp, protocol_err} !== 4'b1_00_0) begin
            n_err++; $display("FAIL l0_rsp: got v=%b resp=%0d perr=%b want v=1 resp=0 perr=0", rsp_valid, rsp_resp, protocol_err);
        end
        rsp_accept();
    endtask

    task automatic test_read_len15_slverr();
        int delivered = 0;
        int last_errs = 0;
        issue_cmd(1'b0, 32'h300, 4'd15, 4'd1);
        ar_accept();
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            M_RValid = 1'b1; M_RData = 32'h1000 + i; M_RID = 4'd1;
            M_RResp = (i == 7) ? SLVERR : OKAY; M_RLast = (i == 15);
            #1;
            if (rd_valid && M_RReady && rd_data === 32'h1000 + i) delivered++;
            if (rd_last !== (i == 15)) last_errs++;
            tick();
        end
        M_RValid = 1'b0; rd_ready = 1'b0;
        n_cmp++; if (delivered !== 16) begin n_err++; $display("FAIL l15_beats: got %0d want 16", delivered); end
        n_cmp++; if (last_errs !== 0) begin n_err++; $display("FAIL l15_rd_last: got %0d bad beats want 0", last_errs); end
        n_cmp++; if ({rsp_valid, rsp_resp, protocol_err} !== 4'b1_10_0) begin
            n_err++; $display("FAIL l15_rsp: got v=%b resp=%0d perr=%b want v=1 resp=2 perr=0", rsp_valid, rsp_resp, protocol_err);
        end
        rsp_accept();
    endtask

    task automatic test_protocol_err();
        int pulses = 0;
        issue_cmd(1'b0, 32'h100, 4'd3, 4'd2);
        ar_accept();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            M_RValid = 1'b1; M_RData = 32'h0; M_RID = 4'd2; M_RResp = OKAY;
            M_RLast = (i == 1) || (i == 3);
            tick();
            if (protocol_err === 1'b1) pulses++;
        end
        M_RValid = 1'b0; rd_ready = 1'b0;
        rsp_accept();
        if (protocol_err === 1'b1) pulses++;
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL perr_rlast: got %0d pulses want 1", pulses); end

        pulses = 0;
        issue_cmd(1'b1, 32'h600, 4'd0, 4'd2);
        M_AWReady = 1'b1; tick(); M_AWReady = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h77; wr_strb = 4'h3; M_WReady = 1'b1;
        #1;
        n_cmp++; if ({M_WLast, M_WStrb} !== 5'b1_0011) begin
            n_err++; $display("FAIL len0_wlast: got last=%b strb=%h want last=1 strb=3", M_WLast, M_WStrb);
        end
        tick();
        wr_valid = 1'b0; M_WReady = 1'b0;
        M_BValid = 1'b1; M_BID = 4'd5; M_BResp = DECERR;
        tick();
        M_BValid = 1'b0;
        if (protocol_err === 1'b1) pulses++;
        n_cmp++; if ({rsp_valid, rsp_resp} !== 3'b1_11) begin
            n_err++; $display("FAIL bid_rsp: got v=%b resp=%0d want v=1 resp=3", rsp_valid, rsp_resp);
        end
        rsp_accept();
        if (protocol_err === 1'b1) pulses++;
        tick();
        if (protocol_err === 1'b1) pulses++;
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL perr_bid: got %0d pulses want 1", pulses); end
    endtask

    task automatic test_reset_mid_burst();
        issue_cmd(1'b1, 32'h400, 4'd3, 4'd4);
        M_AWReady = 1'b1; tick(); M_AWReady = 1'b0;
        wr_valid = 1'b1; wr_data = 32'hB0; wr_strb = 4'hF; M_WReady = 1'b1;
        tick();
        wr_data = 32'hB1;
        #2 ARESETn = 1'b0;
        #1;
        n_cmp++; if ({M_AWValid, M_ARValid, M_WValid, M_BReady, M_RReady, rsp_valid} !== 6'b0) begin
            n_err++; $display("FAIL mid_rst_valids: got %b want 000000",
                {M_AWValid, M_ARValid, M_WValid, M_BReady, M_RReady, rsp_valid});
        end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL mid_rst_state: got %0d want 0", dbg_state); end
        wr_valid = 1'b0; M_WReady = 1'b0;
        @(negedge ACLK) ARESETn = 1'b1;
        tick();
        issue_cmd(1'b1, 32'h500, 4'd0, 4'd6);
        n_cmp++; if ({M_AWValid, M_AWAddr, M_AWID} !== {1'b1, 32'h500, 4'd6}) begin
            n_err++; $display("FAIL post_rst_aw: got v=%b a=%h id=%0d want v=1 a=500 id=6", M_AWValid, M_AWAddr, M_AWID);
        end
        M_AWReady = 1'b1; tick(); M_AWReady = 1'b0;
        wr_valid = 1'b1; wr_data = 32'hC0; M_WReady = 1'b1;
        #1;
        n_cmp++; if (M_WLast !== 1'b1) begin n_err++; $display("FAIL post_rst_wlast: got %b want 1", M_WLast); end
        tick();
        wr_valid = 1'b0; M_WReady = 1'b0;
        M_BValid = 1'b1; M_BID = 4'd6; M_BResp = OKAY;
        tick();
        M_BValid = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_resp, rsp_write, protocol_err} !== 5'b1_00_1_0) begin
            n_err++; $display("FAIL post_rst_rsp: got v=%b resp=%0d wr=%b perr=%b want v=1 resp=0 wr=1 perr=0",
                rsp_valid, rsp_resp, rsp_write, protocol_err);
        end
        rsp_accept();
    endtask

    initial begin
        ARESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wr_data = '0; wr_strb = '0; wr_valid = 1'b0; rd_ready = 1'b0; rsp_ready = 1'b0;
        M_AWReady = 1'b0; M_WReady = 1'b0; M_BID = '0; M_BResp = '0; M_BValid = 1'b0;
        M_ARReady = 1'b0; M_RID = '0; M_RData = '0; M_RResp = '0; M_RLast = 1'b0; M_RValid = 1'b0;
        for (int i = 0; i < 4; i++) wcap[i] = '0;

        test_reset();
        test_write();
        test_read();
        test_read_len0_toggle();
        test_read_len15_slverr();
        test_protocol_err();
        test_reset_mid_burst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
